aud_rmm_target: RTL and testbench

//  Target (responder) end of the AUD remote-memory-access nibble protocol.
//  - Decodes host frames on the 4-bit AUD bus while aud_nsync_i is low: sync nibble, command nibble,
//    8 address nibbles, and write-data nibbles.
//  - Runs one access on a simple req/ack local memory bus.
//  - Returns a status nibble and, for reads, the read-data nibbles.
//  - Sits on the debug-target side of the pad wrapper, which owns the tristate buffer.

---
 rtl/aud_rmm_pkg.sv | 46 ++++
 rtl/aud_rmm_nib_shift.sv | 64 ++++++
 rtl/aud_rmm_target.sv | 208 ++++++++++++++++++++
 tb/tb_aud_rmm_target.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aud_rmm_pkg.sv
// Shared definitions for the AUD remote-memory-access target: FSM states, command codes,
// status nibbles and size helpers.
package aud_rmm_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StCmd,
    StAddr,
    StWdata,
    StDiscard,
    StTurn,
    StBus,
    StStatus,
    StRdata
  } aud_state_e;

  localparam logic [1:0] AUD_CMD_READ  = 2'b10;
  localparam logic [1:0] AUD_CMD_WRITE = 2'b11;

  // Bit0 of every final status is set so the host knows to move on.
  localparam logic [3:0] ST_BUSY   = 4'b0000;
  localparam logic [3:0] ST_OK     = 4'b0001;
  localparam logic [3:0] ST_BUSERR = 4'b0011;
  localparam logic [3:0] ST_TMO    = 4'b1001;
  localparam logic [3:0] ST_ALIGN  = 4'b0101;

  // Number of data nibbles carried for a given size code.
  function automatic logic [3:0] nib_count(input logic [1:0] size);
    unique case (size)
      2'd0:    return 4'd1;
      2'd1:    return 4'd2;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Byte-lane mask before it is shifted into place by addr[1:0].
  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    unique case (size)
      2'd0, 2'd1: return 4'b0001;
      2'd2:       return 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/aud_rmm_nib_shift.sv
// 32-bit nibble register with a 3-bit index. Captures nibbles LSB first at the index, or
// presents the nibble at the index for serialisation.
module aud_rmm_nib_shift
  import aud_rmm_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  input  logic        cap_i,
  input  logic [3:0]  nib_i,
  input  logic        adv_i,
  output logic [31:0] cap_data_o,
  output logic [3:0]  nib_o,
  output logic [2:0]  idx_o
);

  logic [31:0] r_data;
  logic [31:0] w_data_d;
  logic [31:0] w_cap;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_d;

  // Contents as they would be with nib_i placed at the current index.
  always_comb begin
    w_cap = r_data;
    w_cap[{r_idx, 2'b00} +: 4] = nib_i;
  end

  // Next contents/index; clear wins over load, load over capture.
  always_comb begin
    w_data_d = r_data;
    w_idx_d  = r_idx;
    if (clr_i) begin
      w_data_d = '0;
      w_idx_d  = '0;
    end else if (load_i) begin
      w_data_d = load_data_i;
      w_idx_d  = '0;
    end else if (cap_i) begin
      w_data_d = w_cap;
      w_idx_d  = r_idx + 3'd1;
    end else if (adv_i) begin
      w_idx_d  = r_idx + 3'd1;
    end
  end

  // Register update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data <= '0;
      r_idx  <= '0;
    end else begin
      r_data <= w_data_d;
      r_idx  <= w_idx_d;
    end
  end

  assign cap_data_o = w_cap;
  assign nib_o      = r_data[{r_idx, 2'b00} +: 4];
  assign idx_o      = r_idx;

endmodule

// File: rtl/aud_rmm_target.sv
// AUD remote-memory-access target: decodes host nibble frames, runs one local-bus access and
// returns status plus read data. Optional AUD_RMM_TGT_ALIGN_CHECK_EN rejects misaligned
// halfword/word accesses with status 0101 instead of issuing them.
module aud_rmm_target
  import aud_rmm_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        aud_nsync_i,
  input  logic [3:0]  aud_data_i,
  output logic [3:0]  aud_data_o,
  output logic        aud_data_oe_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  output logic        busy_o
);

  aud_state_e  r_state, w_state_d;
  logic        r_write;
  logic [1:0]  r_size;
  logic [3:0]  r_status, w_status_d;
  logic        w_status_set;
  logic        r_req, r_we;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic [15:0] r_tmo;

  logic        w_sh_clr, w_sh_load, w_sh_cap, w_sh_adv;
  logic [31:0] w_sh_cap_data;
  logic [3:0]  w_sh_nib;
  logic [2:0]  w_sh_idx;
  logic        w_last, w_addr_done, w_go, w_bus_end, w_misalign;
  logic [31:0] w_go_addr;
  logic [3:0]  w_be;

  aud_rmm_nib_shift u_nib_shift (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (w_sh_clr),
    .load_i      (w_sh_load),
    .load_data_i (bus_rdata_i >> {r_addr[1:0], 3'b000}),
    .cap_i       (w_sh_cap),
    .nib_i       (aud_data_i),
    .adv_i       (w_sh_adv),
    .cap_data_o  (w_sh_cap_data),
    .nib_o       (w_sh_nib),
    .idx_o       (w_sh_idx)
  );

  assign w_last = ({1'b0, w_sh_idx} == (nib_count(r_size) - 4'd1));
  // Reads launch straight from the last address nibble, writes from the stored address.
  assign w_go_addr = (r_state == StAddr) ? w_sh_cap_data : r_addr;
  assign w_be      = lane_mask(r_size) << w_go_addr[1:0];

`ifdef AUD_RMM_TGT_ALIGN_CHECK_EN
  assign w_misalign = ((r_size == 2'd2) && w_go_addr[0]) ||
                      ((r_size == 2'd3) && (w_go_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Next-state decode and shifter/bus control strobes.
  always_comb begin
    w_state_d    = r_state;
    w_sh_clr     = 1'b0;
    w_sh_load    = 1'b0;
    w_sh_cap     = 1'b0;
    w_sh_adv     = 1'b0;
    w_addr_done  = 1'b0;
    w_go         = 1'b0;
    w_bus_end    = 1'b0;
    w_status_set = 1'b0;
    w_status_d   = r_status;
    unique case (r_state)
      StIdle: begin
        if (!aud_nsync_i && (aud_data_i == 4'h0)) begin
          w_state_d = StCmd;
          w_sh_clr  = 1'b1;
        end
      end
      StCmd: begin
        if (aud_nsync_i) begin
          w_state_d = StIdle;
        end else if ((aud_data_i[3:2] == AUD_CMD_READ) || (aud_data_i[3:2] == AUD_CMD_WRITE)) begin
          w_state_d = StAddr;
        end else begin
          w_state_d = StDiscard;
        end
      end
      StAddr: begin
        if (aud_nsync_i) begin
          w_state_d = StIdle;
        end else if (w_sh_idx == 3'd7) begin
          w_addr_done = 1'b1;
          w_sh_clr    = 1'b1;
          if (r_write) begin
            w_state_d = StWdata;
          end else begin
            w_state_d = StTurn;
            w_go      = 1'b1;
          end
        end else begin
          w_sh_cap = 1'b1;
        end
      end
      StWdata: begin
        if (aud_nsync_i) begin
          w_state_d = StIdle;
        end else begin
          w_sh_cap = 1'b1;
          if (w_last) begin
            w_state_d = StTurn;
            w_go      = 1'b1;
          end
        end
      end
      StDiscard: begin
        if (aud_nsync_i) w_state_d = StIdle;
      end
      StTurn, StBus: begin
        // nsync is deliberately ignored: once requested, the access always completes.
        if (!r_req) begin
          w_state_d = StStatus;
        end else if (bus_err_i) begin
          w_state_d = StStatus; w_bus_end = 1'b1; w_status_set = 1'b1; w_status_d = ST_BUSERR;
        end else if (bus_ack_i) begin
          w_state_d = StStatus; w_bus_end = 1'b1; w_status_set = 1'b1; w_status_d = ST_OK;
          w_sh_load = !r_write;
        end else if (r_tmo == 16'(BUS_TIMEOUT)) begin
          w_state_d = StStatus; w_bus_end = 1'b1; w_status_set = 1'b1; w_status_d = ST_TMO;
        end else begin
          w_state_d = StBus;
        end
      end
      StStatus: begin
        if (!r_write && (r_status == ST_OK)) w_state_d = StRdata;
        else if (aud_nsync_i)                w_state_d = StIdle;
      end
      StRdata: begin
        w_sh_adv = 1'b1;
        if (w_last) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    if (w_go && w_misalign) begin
      w_status_set = 1'b1;
      w_status_d   = ST_ALIGN;
    end
  end

  // State, frame header, bus request and timeout counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= StIdle;
      r_write  <= 1'b0;
      r_size   <= 2'd0;
      r_status <= ST_BUSY;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_tmo    <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StCmd) begin
        r_write <= (aud_data_i[3:2] == AUD_CMD_WRITE);
        r_size  <= aud_data_i[1:0];
      end
      if (w_status_set) r_status <= w_status_d;
      if (w_addr_done)  r_addr   <= w_sh_cap_data;
      if (w_go) begin
        r_req   <= !w_misalign;
        r_we    <= r_write;
        r_be    <= w_be;
        r_wdata <= r_write ? (w_sh_cap_data << {w_go_addr[1:0], 3'b000}) : 32'h0;
        r_tmo   <= '0;
      end else if (w_bus_end) begin
        r_req <= 1'b0;
      end
      if ((r_state == StTurn) || (r_state == StBus)) r_tmo <= r_tmo + 16'd1;
    end
  end

  // Pad drive: busy nibbles, status, then read data.
  always_comb begin
    aud_data_o = ST_BUSY;
    if (r_state == StStatus)     aud_data_o = r_status;
    else if (r_state == StRdata) aud_data_o = w_sh_nib;
  end

  assign aud_data_oe_o = (r_state == StBus) || (r_state == StStatus) || (r_state == StRdata);
  assign busy_o        = (r_state != StIdle);
  assign bus_req_o     = r_req;
  assign bus_we_o      = r_we;
  assign bus_addr_o    = r_addr;
  assign bus_be_o      = r_be;
  assign bus_wdata_o   = r_wdata;

endmodule

// File: tb/tb_aud_rmm_target.sv
// Self-checking bench for aud_rmm_target: directed protocol cases plus randomized frames,
// each checked against expectations computed from the protocol rules.
module tb_aud_rmm_target;

  localparam int TMO = 255;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        nsync;
  logic [3:0]  din;
  logic [3:0]  dout;
  logic        oe, req, we, ack, berr_in, busy;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  aud_rmm_target #(.BUS_TIMEOUT(TMO)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .aud_nsync_i   (nsync),
    .aud_data_i    (din),
    .aud_data_o    (dout),
    .aud_data_oe_o (oe),
    .bus_req_o     (req),
    .bus_we_o      (we),
    .bus_addr_o    (addr),
    .bus_be_o      (be),
    .bus_wdata_o   (wdata),
    .bus_rdata_i   (rdata),
    .bus_ack_i     (ack),
    .bus_err_i     (berr_in),
    .busy_o        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_hdr(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                          input int n_addr);
    @(negedge clk_i);
    nsync = 1'b0;
    din   = 4'h0;
    @(negedge clk_i);
    din = {(wr ? 2'b11 : 2'b10), sz};
    for (int i = 0; i < n_addr; i++) begin
      @(negedge clk_i);
      din = a[4*i +: 4];
    end
  endtask

  // One complete frame; dly = cycles after request before the responder answers
  // (0 = in the turnaround cycle, > TMO = never).
  task automatic run_txn(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int dly,
                         input bit fail, input int hold);
    int          n, lanes, off, be_int, stat_t;
    bit          misal, rd_ok;
    logic [3:0]  st, be_exp;
    logic [31:0] mask, w_exp, r_exp;
    n      = 1 << sz;
    lanes  = (sz == 2'd3) ? 4 : (sz == 2'd2) ? 2 : 1;
    off    = int'(a[1:0]);
    be_int = ((1 << lanes) - 1) << off;
    be_exp = be_int[3:0];
    mask   = (n == 8) ? 32'hFFFF_FFFF : 32'((1 << (4 * n)) - 1);
    w_exp  = (wd & mask) << (8 * off);
    r_exp  = rd >> (8 * off);
    misal  = 1'b0;
`ifdef AUD_RMM_TGT_ALIGN_CHECK_EN
    misal = ((sz == 2'd2) && a[0]) || ((sz == 2'd3) && (a[1:0] != 2'b00));
`endif
    if (misal) begin
      st = 4'b0101; stat_t = 1;
    end else if (dly > TMO) begin
      st = 4'b1001; stat_t = TMO + 1;
    end else begin
      st = fail ? 4'b0011 : 4'b0001; stat_t = dly + 1;
    end
    rd_ok = !wr && (st == 4'b0001);

    send_hdr(wr, sz, a, 8);
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        @(negedge clk_i);
        din = wd[4*i +: 4];
      end
    end
    for (int t = 0; t < stat_t; t++) begin
      @(negedge clk_i);
      ack     = 1'b0;
      berr_in = 1'b0;
      chk("resp_oe", oe, (t > 0));
      if (t > 0) chk("busy_nibble", dout, 4'h0);
      chk("req_level", req, !misal);
      chk("busy_o", busy, 1'b1);
      if ((t == 0) && !misal) begin
        chk("bus_we", we, wr);
        chk("bus_addr", addr, a);
        chk("bus_be", be, be_exp);
        if (wr) chk("bus_wdata", wdata, w_exp);
      end
      din = 4'($urandom);
      if (!misal && (t == dly)) begin
        if (fail) berr_in = 1'b1;
        else      ack     = 1'b1;
        rdata = rd;
      end else begin
        rdata = $urandom;
      end
    end
    @(negedge clk_i);
    ack     = 1'b0;
    berr_in = 1'b0;
    chk("status", dout, st);
    chk("status_oe", oe, 1'b1);
    chk("req_dropped", req, 1'b0);
    if (rd_ok) begin
      for (int i = 0; i < n; i++) begin
        @(negedge clk_i);
        chk("rdata_nibble", dout, r_exp[4*i +: 4]);
        chk("rdata_oe", oe, 1'b1);
        nsync = 1'b1;
      end
    end else begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk_i);
        chk("status_hold", dout, st);
        chk("status_hold_oe", oe, 1'b1);
      end
      nsync = 1'b1;
    end
    @(negedge clk_i);
    chk("end_oe", oe, 1'b0);
    chk("end_busy", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i   = 1'b1;
    nsync   = 1'b1;
    din     = 4'h0;
    ack     = 1'b0;
    berr_in = 1'b0;
    rdata   = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_data", dout, 4'h0);
    chk("rst_oe", oe, 1'b0);
    chk("rst_req", req, 1'b0);
    chk("rst_we", we, 1'b0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_be", be, 4'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_busy", busy, 1'b0);
    rst_i = 1'b0;

    // Word write, ack after 3 cycles.
    run_txn(1'b1, 2'd3, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 3, 1'b0, 2);
    // Byte read at lane 3, zero-wait ack, issued back-to-back.
    run_txn(1'b0, 2'd1, 32'h2000_0003, 32'h0, 32'hAB00_0000, 0, 1'b0, 0);
    // Bus error on a read.
    run_txn(1'b0, 2'd3, 32'h0000_0100, 32'h0, 32'h5555_AAAA, 1, 1'b1, 3);
    // No response: timeout.
    run_txn(1'b0, 2'd3, 32'h0000_0200, 32'h0, 32'h0, 1000, 1'b0, 1);
    // Word read at offset 2 (align-check dependent).
    run_txn(1'b0, 2'd3, 32'h3000_0002, 32'h0, 32'h1122_3344, 1, 1'b0, 1);

    // Abort after the 4th address nibble, then a normal frame.
    send_hdr(1'b1, 2'd3, 32'h1234_5678, 4);
    @(negedge clk_i);
    nsync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("abort_busy", busy, 1'b0);
      chk("abort_req", req, 1'b0);
    end
    run_txn(1'b1, 2'd2, 32'h0000_0040, 32'h0000_9876, 32'h0, 0, 1'b0, 1);

    // Non-zero sync nibble is ignored.
    @(negedge clk_i);
    nsync = 1'b0;
    din   = 4'h5;
    @(negedge clk_i);
    chk("bad_sync_busy", busy, 1'b0);
    nsync = 1'b1;

    // Non-access command is discarded without driving.
    @(negedge clk_i);
    nsync = 1'b0;
    din   = 4'h0;
    @(negedge clk_i);
    din = 4'h4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("discard_busy", busy, 1'b1);
      chk("discard_oe", oe, 1'b0);
      chk("discard_req", req, 1'b0);
      din = 4'($urandom);
    end
    nsync = 1'b1;
    @(negedge clk_i);
    chk("discard_end_busy", busy, 1'b0);

    // Reset in the middle of a bus access.
    send_hdr(1'b0, 2'd3, 32'h0000_0010, 8);
    @(negedge clk_i);
    chk("mid_req", req, 1'b1);
    @(negedge clk_i);
    chk("mid_oe", oe, 1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("mid_rst_oe", oe, 1'b0);
    chk("mid_rst_req", req, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_addr", addr, 32'h0);
    chk("mid_rst_data", dout, 4'h0);
    rst_i = 1'b0;
    nsync = 1'b1;

    // Randomized frames.
    for (int k = 0; k < 24; k++) begin
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
              $urandom, int'($urandom_range(0, 4)), ($urandom_range(0, 4) == 0),
              int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
